// File: rtl/led_breathe_pkg.sv
// Shared types and default sizing for the breathing-LED driver.
package led_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam int PWM_BITS_DEF    = 8;
  localparam int STEP_CYCLES_DEF = 196078;
endpackage

// File: rtl/led_breathe_if.sv
// Control/status bundle between the breathing-LED driver and its surroundings.
interface led_breathe_if
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
);
  logic                en;
  logic                LED;
  logic [PWM_BITS-1:0] level;
  logic                dir;

  modport master (output en, input LED, level, dir);
  modport slave  (input en, output LED, level, dir);
endinterface

// File: rtl/led_breathe_pwm_gen.sv
// PWM generator: free-running counter, duty latched only at wrap, registered compare.
module pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [PWM_BITS-1:0] duty,
  output logic                LED
);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      LED     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      // duty only changes at the period boundary so no period is ever split
      if (pwm_cnt == '1)
        duty_q <= duty;
      LED <= (pwm_cnt < duty_q);
    end
  end
endmodule

// File: rtl/led_breathe.sv
// Breathing-LED driver: triangle brightness ramp feeding a PWM output.
// Define LED_BREATHE_GAMMA_EN to square the level (one registered stage) before PWM.
module led_breathe
  import led_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  led_breathe_if.slave   bus
);
  localparam int                PW         = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] MAX_M1   = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);

  state_t              state;
  logic [PWM_BITS-1:0] level;
  logic                dir;
  logic [PW-1:0]       presc;
  logic                tick;
  logic                clr;
  logic [PWM_BITS-1:0] duty_src;

  assign tick = (presc == PRESC_LAST);
  // PWM is idled on the same edge that the FSM drops back to IDLE
  assign clr  = (state == IDLE) || !bus.en;

  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      state <= IDLE;
      level <= '0;
      dir   <= 1'b0;
      presc <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= UP;
          dir   <= 1'b1;
          level <= '0;
          presc <= '0;
        end
        UP: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (level == MAX_M1) begin
              level <= '1;
              state <= DOWN;
              dir   <= 1'b0;
            end else begin
              level <= level + 1'b1;
            end
          end
        end
        DOWN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (level == ONE) begin
              level <= '0;
              state <= UP;
              dir   <= 1'b1;
            end else begin
              level <= level - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          level <= '0;
          dir   <= 1'b0;
          presc <= '0;
        end
      endcase
    end
  end

`ifdef LED_BREATHE_GAMMA_EN
  function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] l);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, l} * {{PWM_BITS{1'b0}}, l};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

  logic [PWM_BITS-1:0] duty_p1;

  // ---- stage p1: squared level ----
  always_ff @(posedge clk) begin
    if (rst || clr)
      duty_p1 <= '0;
    else
      duty_p1 <= gamma(level);
  end

  assign duty_src = duty_p1;
`else
  assign duty_src = level;
`endif

  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .duty (duty_src),
    .LED  (bus.LED)
  );

  assign bus.level = level;
  assign bus.dir   = dir;
endmodule

// File: tb/tb_led_breathe.sv
// Directed self-checking bench for led_breathe (PWM_BITS=4, STEP_CYCLES=4, plus a STEP_CYCLES=7 copy).
module tb_led_breathe;
  localparam int PB  = 4;
  localparam int SC  = 4;
  localparam int SC7 = 7;
  localparam int NLOG = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_breathe_if #(.PWM_BITS(PB)) bus  ();
  led_breathe_if #(.PWM_BITS(PB)) bus7 ();

  led_breathe #(.PWM_BITS(PB), .STEP_CYCLES(SC))  dut  (.clk(clk), .rst(rst), .bus(bus));
  led_breathe #(.PWM_BITS(PB), .STEP_CYCLES(SC7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  int checks   = 0;
  int failures = 0;

  logic [PB-1:0] lvl_log  [0:NLOG-1];
  logic          dir_log  [0:NLOG-1];
  logic          led_log  [0:NLOG-1];
  logic          led7_log [0:NLOG-1];

  // Expected level k cycles after entering UP: 15 steps up, 15 steps down, repeat.
  function automatic int model_level(input int kk, input int sc);
    int s;
    s = (kk / sc) % 30;
    return (s <= 15) ? s : 30 - s;
  endfunction

  function automatic logic model_dir(input int kk, input int sc);
    return ((kk / sc) % 30) < 15;
  endfunction

  // Duty in force for PWM window m (cycles 16m+1 .. 16m+16 after entering UP).
  function automatic int exp_duty(input int m, input int sc);
    int l;
    if (m == 0) return 0;
`ifdef LED_BREATHE_GAMMA_EN
    l = model_level(16*m - 2, sc);
    return (l * l) >> PB;
`else
    l = model_level(16*m - 1, sc);
    return l;
`endif
  endfunction

  // Reset, release, and stop at the first negedge after the IDLE->UP edge.
  task automatic start_run();
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b1; bus7.en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b1; bus7.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.LED !== 1'b0 || bus.level !== 4'd0 || bus.dir !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d LED=%b level=%0d dir=%b required 0/0/0", i, bus.LED, bus.level, bus.dir);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dir !== 1'b1 || bus.level !== 4'd0) begin
      failures++;
      $display("FAIL reset_release dir=%b level=%0d required dir=1 level=0", bus.dir, bus.level);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.level !== ((i == 4) ? 4'd1 : 4'd0)) begin
        failures++;
        $display("FAIL first_step cyc=%0d level=%0d required %0d", i, bus.level, (i == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic capture_run();
    start_run();
    for (int i = 0; i < NLOG; i++) begin
      lvl_log[i]  = bus.level;
      dir_log[i]  = bus.dir;
      led_log[i]  = bus.LED;
      led7_log[i] = bus7.LED;
      @(negedge clk);
    end
  endtask

  task automatic test_full_ramp();
    for (int i = 0; i < NLOG; i++) begin
      checks++;
      if (lvl_log[i] !== 4'(model_level(i, SC)) || dir_log[i] !== model_dir(i, SC)) begin
        failures++;
        $display("FAIL ramp k=%0d level=%0d dir=%b required level=%0d dir=%b",
                 i, lvl_log[i], dir_log[i], model_level(i, SC), model_dir(i, SC));
      end
    end
  endtask

  task automatic test_duty_accuracy();
    for (int m = 0; m <= 8; m++) begin
      int highs;
      highs = 0;
      for (int j = 16*m + 1; j <= 16*m + 16; j++)
        if (led_log[j] === 1'b1) highs++;
      checks++;
      if (highs != exp_duty(m, SC)) begin
        failures++;
        $display("FAIL duty window=%0d high_cycles=%0d required %0d", m, highs, exp_duty(m, SC));
      end
    end
  endtask

  task automatic test_gamma();
    int highs, req;
    // STEP_CYCLES=7 copy: window 4 latches level 8 (gamma path) or level 9 (direct path)
`ifdef LED_BREATHE_GAMMA_EN
    req = 4;
`else
    req = 9;
`endif
    highs = 0;
    for (int j = 65; j <= 80; j++)
      if (led7_log[j] === 1'b1) highs++;
    checks++;
    if (highs != req) begin
      failures++;
      $display("FAIL gamma_step7 high_cycles=%0d required %0d", highs, req);
    end
    // main copy: window 4 carries level 15
`ifdef LED_BREATHE_GAMMA_EN
    req = 14;
`else
    req = 15;
`endif
    highs = 0;
    for (int j = 65; j <= 80; j++)
      if (led_log[j] === 1'b1) highs++;
    checks++;
    if (highs != req) begin
      failures++;
      $display("FAIL gamma_level15 high_cycles=%0d required %0d", highs, req);
    end
  endtask

  task automatic test_mid_disable();
    int highs;
    start_run();
    repeat (31) @(negedge clk);
    checks++;
    if (bus.level !== 4'd7 || bus.dir !== 1'b1) begin
      failures++;
      $display("FAIL disable_pre level=%0d dir=%b required 7/1", bus.level, bus.dir);
    end
    // next edge is a step tick; disable must win
    bus.en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.level !== 4'd0 || bus.LED !== 1'b0 || bus.dir !== 1'b0) begin
      failures++;
      $display("FAIL disable level=%0d LED=%b dir=%b required 0/0/0", bus.level, bus.LED, bus.dir);
    end
    bus.en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.level !== 4'd0 || bus.dir !== 1'b1) begin
      failures++;
      $display("FAIL reenable level=%0d dir=%b required 0/1", bus.level, bus.dir);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.level !== 4'd1) begin
      failures++;
      $display("FAIL reenable_step level=%0d required 1", bus.level);
    end
    highs = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.LED === 1'b1) highs++;
      @(negedge clk);
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL reenable_led high_cycles=%0d required 0", highs);
    end
  endtask

  task automatic test_reset_midop();
    int highs;
    start_run();
    repeat (81) @(negedge clk);
    checks++;
    if (bus.level !== 4'd10 || bus.dir !== 1'b0 || bus.LED !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre level=%0d dir=%b LED=%b required 10/0/1", bus.level, bus.dir, bus.LED);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.level !== 4'd0 || bus.dir !== 1'b0 || bus.LED !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid cyc=%0d level=%0d dir=%b LED=%b required 0/0/0", i, bus.level, bus.dir, bus.LED);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.level !== 4'd0 || bus.dir !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_release level=%0d dir=%b required 0/1", bus.level, bus.dir);
    end
    highs = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (bus.LED === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL rst_mid_led high_cycles=%0d required 0", highs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en  = 1'b0;
    bus7.en = 1'b0;
    test_reset();
    capture_run();
    test_full_ramp();
    test_duty_accuracy();
    test_gamma();
    test_mid_disable();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
